// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned NxN->2N add-and-shift multiplier; one ripple-carry add per clock.
// Optional ZERO_BYPASS_EN: zero operands skip the iterations and finish in one cycle.
module shift_add_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshake: start is sampled only in IDLE; done is a one-cycle pulse in DONE,
    // busy covers every non-IDLE cycle. There is no queueing of requests.

    logic [1:0]    state;
    logic [N-1:0]  mcand;
    logic [N-1:0]  acc_hi;
    logic [N-1:0]  acc_lo;
    logic [CW-1:0] cnt;

    logic [N-1:0]  add_a;
    logic [N-1:0]  add_b;
    logic [N-1:0]  sum;
    logic          cout;
    logic          carry;

    assign add_a = acc_hi;
    assign add_b = acc_lo[0] ? mcand : '0;

    // Shared N-bit ripple-carry adder, cin tied to zero.
    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = add_a[i] ^ add_b[i] ^ carry;
            carry  = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
        end
        cout = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        cnt    <= '0;
`ifdef ZERO_BYPASS_EN
                        if ((a == '0) || (b == '0)) begin
                            acc_lo <= '0;
                            state  <= DONE;
                        end else begin
                            acc_lo <= b;
                            state  <= RUN;
                        end
`else
                        acc_lo <= b;
                        state  <= RUN;
`endif
                    end
                end
                RUN: begin
                    // cout becomes the new MSB so the carry out of each add is kept.
                    acc_hi <= {cout, sum[N-1:1]};
                    acc_lo <= {sum[0], acc_lo[N-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl: transaction-level model plus directed vectors.
module tb_shift_add_mult_ctrl;

  localparam int N = 8;

`ifdef ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = N + 1;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 0;

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // model: cycles of busy remaining, and the product the requester should see
  int             m_left  = 0;
  logic [2*N-1:0] m_prod  = '0;
  logic [2*N-1:0] m_pend  = '0;
  bit             m_valid = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_prod  = '0;
      m_valid = 1'b1;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend = (2*N)'(a) * (2*N)'(b);
`ifdef ZERO_BYPASS_EN
        if (a == '0 || b == '0) begin
          m_left  = 1;
          m_prod  = '0;
          m_valid = 1'b1;
        end else begin
          m_left  = N + 1;
          m_valid = 1'b0;
        end
`else
        m_left  = N + 1;
        m_valid = 1'b0;
`endif
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_prod  = m_pend;
        m_valid = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_left == 1));
      if (m_valid) chk("product", 64'(product), 64'(m_prod));
    end
  end

  // driver tasks
  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 40);
  endtask

  task automatic run_op(input string name, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [2*N-1:0] exp_p, input int exp_lat);
    int k;
    @(posedge clk);
    #1 a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(k);
    chk({name, "_latency"}, 64'(k), 64'(exp_lat));
    chk({name, "_product"}, 64'(product), 64'(exp_p));
  endtask

  initial begin
    int k;
    bit got;
    rst_n = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #3 rst_n = 1'b0;
    checking = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 a = N'($urandom_range(0, 255)); b = N'($urandom_range(0, 255));
      start = 1'($urandom_range(0, 1));
    end
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    #2 rst_n = 1'b1;

    run_op("mul_13x11", 8'd13, 8'd11, 16'h008F, N + 1);
    run_op("mul_255x255", 8'd255, 8'd255, 16'hFE01, N + 1);
    run_op("mul_1x128", 8'd1, 8'd128, 16'h0080, N + 1);
    run_op("mul_128x2", 8'd128, 8'd2, 16'h0100, N + 1);

    // start held high with changing operands during the run
    @(posedge clk);
    #1 a = 8'd3; b = 8'd5; start = 1'b1;
    @(posedge clk);
    k = 0;
    got = 0;
    while (k < 40 && !got) begin
      #1 a = 8'(k + 40); b = 8'(k + 3);
      @(negedge clk);
      k++;
      if (done) got = 1;
      else @(posedge clk);
    end
    chk("held_latency", 64'(k), 64'(N + 1));
    chk("held_product", 64'(product), 64'd15);
    @(posedge clk);
    #1 a = 8'd6; b = 8'd7;
    @(negedge clk);
    chk("held_idle_busy", 64'(busy), 64'd0);
    chk("held_idle_product", 64'(product), 64'd15);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(k);
    chk("held_next_latency", 64'(k), 64'(N + 1));
    chk("held_next_product", 64'(product), 64'd42);

    // reset in the middle of a run
    @(posedge clk);
    #1 a = 8'd200; b = 8'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", 64'(product), 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1 a = N'($urandom_range(0, 255)); b = N'($urandom_range(0, 255));
      start = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1 start = 1'b0;
    #2 rst_n = 1'b1;
    run_op("mul_7x9", 8'd7, 8'd9, 16'd63, N + 1);

    run_op("mul_0x200", 8'd0, 8'd200, 16'd0, ZERO_LAT);
    run_op("mul_200x0", 8'd200, 8'd0, 16'd0, ZERO_LAT);
    run_op("mul_2x3", 8'd2, 8'd3, 16'd6, N + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
